// File: rtl/pipeline_v1r1_accum.sv
// pipeline_v1r1_accum
// Valid/ready pipeline stage that adds each accepted value into a running
// packet sum. The sum is cleared after the beat that carries i_last. Results
// pass through DEPTH register slices, with a one-entry skid buffer in front.
// o_ready, o_valid and the output data therefore all come from registers.
//
// Ports:
//   clock    - single clock, all logic on posedge
//   reset    - synchronous, active-high
//   i_value  - upstream data (VALUE_BITS)
//   i_last   - upstream end-of-packet, qualified by i_valid
//   i_valid  - upstream valid
//   o_ready  - registered ready to upstream
//   o_value  - accumulated result, forced to zero while o_valid=0
//   o_last   - i_last carried alongside its beat
//   o_valid  - registered valid to downstream
//   i_ready  - downstream ready
//   o_busy   - a beat is held in the skid buffer or in any stage
module pipeline_v1r1_accum #(
  parameter int VALUE_BITS = 8,
  parameter int STATE_BITS = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [VALUE_BITS-1:0] i_value,
  input  logic                  i_last,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [VALUE_BITS-1:0] o_value,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy
);

  localparam int SUM_BITS = ((VALUE_BITS > STATE_BITS) ? VALUE_BITS : STATE_BITS) + 1;

  logic [STATE_BITS-1:0] r_state;
  logic                  r_ready;
  logic                  r_skid_valid;
  logic [VALUE_BITS-1:0] r_skid_value;
  logic                  r_skid_last;
  logic [DEPTH:1]        r_stg_valid;
  logic [DEPTH:1]        r_stg_last;
  logic [VALUE_BITS-1:0] r_stg_value [1:DEPTH];

  logic                  w_accept;
  logic [SUM_BITS-1:0]   w_sum;
  logic [VALUE_BITS-1:0] w_n_value;
  logic [STATE_BITS-1:0] w_n_state;
  logic [DEPTH:1]        w_load;
  logic                  w_src_valid;
  logic [VALUE_BITS-1:0] w_src_value;
  logic                  w_src_last;
  logic                  w_skid_valid_next;
  logic                  w_skid_load;

  assign w_accept  = i_valid & r_ready;
  assign w_sum     = SUM_BITS'(i_value) + SUM_BITS'(r_state);
  assign w_n_value = w_sum[VALUE_BITS-1:0];
  assign w_n_state = i_last ? '0 : w_sum[STATE_BITS-1:0];

  // Stage k may load when it or any stage downstream of it has a hole, or
  // when the output is being taken. This makes bubbles collapse. Writing it
  // as a flat reduction keeps the chain free of combinational self-loops.
  generate
    for (genvar k = 1; k <= DEPTH; k++) begin : g_load
      assign w_load[k] = i_ready | ~(&r_stg_valid[DEPTH:k]);
    end
  endgenerate

  // Stage 0 is the head-of-line beat. A held skid entry is older than the
  // incoming beat, so it goes first.
  assign w_src_valid = r_skid_valid | w_accept;
  assign w_src_value = r_skid_valid ? r_skid_value : w_n_value;
  assign w_src_last  = r_skid_valid ? r_skid_last  : i_last;

  // An accepted beat lands in the skid when it cannot go straight into stage 1.
  assign w_skid_load       = w_accept & (r_skid_valid | ~w_load[1]);
  assign w_skid_valid_next = w_skid_load | (r_skid_valid & ~w_load[1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= '0;
      r_ready      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_value <= '0;
      r_skid_last  <= 1'b0;
      r_stg_valid  <= '0;
      r_stg_last   <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        r_stg_value[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_state <= w_n_state;
      end
      // Ready looks one cycle ahead. A beat accepted on the edge that fills
      // the skid is still safe, because that beat is the one that fills it.
      r_ready      <= ~w_skid_valid_next;
      r_skid_valid <= w_skid_valid_next;
      if (w_skid_load) begin
        r_skid_value <= w_n_value;
        r_skid_last  <= i_last;
      end
      if (w_load[1]) begin
        r_stg_valid[1] <= w_src_valid;
        r_stg_value[1] <= w_src_value;
        r_stg_last[1]  <= w_src_last;
      end
      for (int k = 2; k <= DEPTH; k++) begin
        if (w_load[k]) begin
          r_stg_valid[k] <= r_stg_valid[k-1];
          r_stg_value[k] <= r_stg_value[k-1];
          r_stg_last[k]  <= r_stg_last[k-1];
        end
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_stg_valid[DEPTH];
  assign o_value = r_stg_value[DEPTH] & {VALUE_BITS{r_stg_valid[DEPTH]}};
  assign o_last  = r_stg_last[DEPTH] & r_stg_valid[DEPTH];
  assign o_busy  = r_skid_valid | (|r_stg_valid);

endmodule
